acc_sched_ctrl: RTL
===================

ACC_SCHED_CTRL -- requirements
Module: acc_sched_ctrl

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing the accelerator (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, 60000000, BUSY cycles allowed before a job is aborted (32-bit, >= 2).
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  NUM_REQ  per-requester job request, level; held until that requester's o_done or o_err.
REQ-006 o_grant  output  NUM_REQ  one-hot owner of the accelerator; all-zero when idle.
REQ-007 o_done  output  NUM_REQ  one-cycle pulse: owner's job finished normally.
REQ-008 o_err  output  NUM_REQ  one-cycle pulse: owner's job aborted on timeout.
REQ-009 o_acc_start  output  1  accelerator start, to accelerator i_start.
REQ-010 i_acc_finish  input  1  accelerator finish level; stays high until the next accepted start.
REQ-011 o_acc_reset  output  1  active-high synchronous reset to the accelerator, used for abort recovery.
REQ-012 o_busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, START, BUSY, DONE, ABORT1, ABORT2; all outputs registered.
REQ-014 IDLE: if any i_req bit is set, select winner by round-robin from pointer ptr (lowest index >= ptr, wrapping); next state START; otherwise stay.
REQ-015 START lasts exactly one cycle: o_grant = winner one-hot, o_acc_start = 1; next state BUSY.
REQ-016 o_acc_start is high only in START; it is never high two consecutive cycles.
REQ-017 finish_q = i_acc_finish registered every cycle; finish_rise = i_acc_finish & ~finish_q.
REQ-018 BUSY: timeout counter increments each cycle from 0; finish_rise -> DONE; counter == TIMEOUT_CYCLES-1 without finish_rise -> ABORT1.
REQ-019 finish_rise and timeout in the same cycle: finish_rise wins, next state DONE.
REQ-020 A stale high i_acc_finish from a previous job does not cause a rise: the accelerator clears it on the edge that ends START.
REQ-021 DONE lasts one cycle: o_done[owner] = 1, o_grant held; then IDLE with o_grant = 0, ptr = (owner+1) mod NUM_REQ.
REQ-022 ABORT1: o_err[owner] = 1, o_acc_reset = 1; ABORT2: o_acc_reset = 1, o_err = 0; then IDLE, o_grant = 0, ptr = (owner+1) mod NUM_REQ.
REQ-023 Owner deasserting i_req during START/BUSY does not abort the job; the done/err pulse is still issued.
REQ-024 Requests from non-owners during a job are ignored until IDLE; at most one new grant per IDLE visit.
REQ-025 Minimum gap from DONE or ABORT2 to the next START is one IDLE cycle.

Reset
REQ-026 reset_n low asynchronously forces: state IDLE, o_grant/o_done/o_err = 0, o_acc_start = 0, o_acc_reset = 0, o_busy = 0, ptr = 0, counter = 0, finish_q = 0.
REQ-027 Reset assertion mid-job abandons the job with no o_done/o_err pulse; release is synchronised to clk by the system.

Structure
REQ-028 Package acc_pkg holds the FSM state type, the state encodings and the default NUM_REQ and TIMEOUT_CYCLES.
REQ-029 Round-robin selection is a combinational sub-module acc_rr_pick (inputs req and ptr; outputs one-hot grant and valid); the FSM, counter and edge detect stay in acc_sched_ctrl.

Verification (bench: NUM_REQ=4, TIMEOUT_CYCLES=20; accelerator model with NUM_CICLOS=10)
REQ-030 Single request: i_req=0001 -> o_acc_start one cycle, o_grant=0001, o_done=0001 one cycle about 12 cycles after START, then o_grant=0000.
REQ-031 Fairness: i_req=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, with one done per grant.
REQ-032 Timeout: accelerator finish stuck at 0, i_req=0100 -> o_err=0100 at BUSY cycle 20, o_acc_reset high 2 cycles, then IDLE, ptr=3.
REQ-033 Stale finish: i_acc_finish left high after job 1, new i_req=0010 -> no premature o_done; done only after the new rise.
REQ-034 Reset mid-BUSY: reset_n low for 1 cycle -> all outputs 0 immediately, no done/err pulse; next i_req=1000 is granted from ptr=0.
REQ-035 Owner drops i_req in BUSY -> job completes and o_done is still pulsed for that requester.

Source files
------------

// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// Module      : acc_pkg
// Description : Shared types and defaults for the accelerator scheduler.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package acc_pkg;

  localparam int          c_default_num_req = 4;
  localparam int unsigned c_default_timeout = 32'd60000000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_BUSY   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ABORT1 = 3'd4,
    ST_ABORT2 = 3'd5
  } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/acc_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// Module      : acc_sched_ctrl_if
// Description : Requester and accelerator handshake bundle of the scheduler.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface acc_sched_ctrl_if
  import acc_pkg::*;
#(
  parameter int NUM_REQ = c_default_num_req
);

  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] o_grant;
  logic [NUM_REQ-1:0] o_done;
  logic [NUM_REQ-1:0] o_err;
  logic               o_acc_start;
  logic               i_acc_finish;
  logic               o_acc_reset;
  logic               o_busy;

  // slave = scheduler side, master = requesters plus accelerator side
  modport slave (
    input  i_req, i_acc_finish,
    output o_grant, o_done, o_err, o_acc_start, o_acc_reset, o_busy
  );

  modport master (
    output i_req, i_acc_finish,
    input  o_grant, o_done, o_err, o_acc_start, o_acc_reset, o_busy
  );

endinterface

`default_nettype wire

// File: rtl/acc_rr_pick.sv
// ---------------------------------------------------------------------------
// Module      : acc_rr_pick
// Description : Combinational round-robin pick: lowest requester >= ptr, wrapping.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module acc_rr_pick
  import acc_pkg::*;
#(
  parameter int NUM_REQ = c_default_num_req,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [PTR_W-1:0]   ptr,
  output logic      [NUM_REQ-1:0] grant,
  output logic                    valid
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/acc_sched_ctrl.sv
// ---------------------------------------------------------------------------
// Module      : acc_sched_ctrl
// Description : Shares one accelerator among NUM_REQ requesters with timeout abort.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module acc_sched_ctrl
  import acc_pkg::*;
#(
  parameter int          NUM_REQ        = c_default_num_req,
  parameter int unsigned TIMEOUT_CYCLES = c_default_timeout
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  acc_sched_ctrl_if.slave bus
);

  localparam int                  c_ptr_w    = $clog2(NUM_REQ);
  localparam logic [c_ptr_w-1:0]  c_last_idx = c_ptr_w'(NUM_REQ - 1);
  localparam logic [31:0]         c_cnt_last = 32'(TIMEOUT_CYCLES - 1);

  acc_state_t         r_state, w_state_d;
  logic [NUM_REQ-1:0] r_grant, w_grant_d;
  logic [NUM_REQ-1:0] r_done, w_done_d;
  logic [NUM_REQ-1:0] r_err, w_err_d;
  logic               r_acc_start, w_acc_start_d;
  logic               r_acc_reset, w_acc_reset_d;
  logic               r_busy, w_busy_d;
  logic [NUM_REQ-1:0] r_owner_oh, w_owner_oh_d;
  logic [c_ptr_w-1:0] r_owner_idx, w_owner_idx_d;
  logic [c_ptr_w-1:0] r_ptr, w_ptr_d, w_next_ptr;
  logic [31:0]        r_cnt, w_cnt_d;
  logic               r_finish_q;
  logic               w_finish_rise;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic               w_pick_valid;
  logic [c_ptr_w-1:0] w_pick_idx;

  acc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (c_ptr_w)
  ) u_pick (
    .req   (bus.i_req),
    .ptr   (r_ptr),
    .grant (w_pick_grant),
    .valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick_grant[k]) w_pick_idx = c_ptr_w'(k);
    end
  end

  // A finish left high by the previous job never looks like a rise here
  assign w_finish_rise = bus.i_acc_finish & ~r_finish_q;
  assign w_next_ptr    = (r_owner_idx == c_last_idx) ? '0 : r_owner_idx + c_ptr_w'(1);

  always_comb begin
    w_state_d     = r_state;
    w_owner_oh_d  = r_owner_oh;
    w_owner_idx_d = r_owner_idx;
    w_ptr_d       = r_ptr;
    w_cnt_d       = r_cnt;
    w_grant_d     = '0;
    w_done_d      = '0;
    w_err_d       = '0;
    w_acc_start_d = 1'b0;
    w_acc_reset_d = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_d     = ST_START;
          w_owner_oh_d  = w_pick_grant;
          w_owner_idx_d = w_pick_idx;
        end
      end
      ST_START: begin
        w_state_d = ST_BUSY;
        w_cnt_d   = '0;
      end
      ST_BUSY: begin
        if (w_finish_rise)             w_state_d = ST_DONE;
        else if (r_cnt == c_cnt_last)  w_state_d = ST_ABORT1;
        else                           w_cnt_d   = r_cnt + 32'd1;
      end
      ST_DONE: begin
        w_state_d = ST_IDLE;
        w_ptr_d   = w_next_ptr;
      end
      ST_ABORT1: w_state_d = ST_ABORT2;
      ST_ABORT2: begin
        w_state_d = ST_IDLE;
        w_ptr_d   = w_next_ptr;
      end
      default: w_state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    case (w_state_d)
      ST_START: begin
        w_grant_d     = w_owner_oh_d;
        w_acc_start_d = 1'b1;
      end
      ST_BUSY:  w_grant_d = w_owner_oh_d;
      ST_DONE: begin
        w_grant_d = w_owner_oh_d;
        w_done_d  = w_owner_oh_d;
      end
      ST_ABORT1: begin
        w_grant_d     = w_owner_oh_d;
        w_err_d       = w_owner_oh_d;
        w_acc_reset_d = 1'b1;
      end
      ST_ABORT2: begin
        w_grant_d     = w_owner_oh_d;
        w_acc_reset_d = 1'b1;
      end
      default: ;
    endcase
    w_busy_d = (w_state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_acc_start <= 1'b0;
      r_acc_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_owner_oh  <= '0;
      r_owner_idx <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_finish_q  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_grant     <= w_grant_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      r_acc_start <= w_acc_start_d;
      r_acc_reset <= w_acc_reset_d;
      r_busy      <= w_busy_d;
      r_owner_oh  <= w_owner_oh_d;
      r_owner_idx <= w_owner_idx_d;
      r_ptr       <= w_ptr_d;
      r_cnt       <= w_cnt_d;
      r_finish_q  <= bus.i_acc_finish;
    end
  end

  assign bus.o_grant     = r_grant;
  assign bus.o_done      = r_done;
  assign bus.o_err       = r_err;
  assign bus.o_acc_start = r_acc_start;
  assign bus.o_acc_reset = r_acc_reset;
  assign bus.o_busy      = r_busy;

endmodule

`default_nettype wire
